// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline event inputs and the stall/flush/divider
// controls returned to the pipeline.
//   master : pipeline side, drives events and receives controls
//   slave  : pipe_hazard_ctrl, receives events and drives controls
// Events   : dcache_busy, div_req, div_done, ld_use, EX_br_a, EX_br_b, WB_flush_csr
// Controls : div_start, div_cancel, stall_dcache, stall_div, stall_front,
//            bubble_ex, flush_front, kill_ex_b, div_timeout, stall_cnt, flush_cnt
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             dcache_busy;
   logic             div_req;
   logic             div_done;
   logic             ld_use;
   logic             EX_br_a;
   logic             EX_br_b;
   logic             WB_flush_csr;

   logic             div_start;
   logic             div_cancel;
   logic             stall_dcache;
   logic             stall_div;
   logic             stall_front;
   logic             bubble_ex;
   logic             flush_front;
   logic             kill_ex_b;
   logic             div_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output dcache_busy, div_req, div_done, ld_use, EX_br_a, EX_br_b, WB_flush_csr,
      input  div_start, div_cancel, stall_dcache, stall_div, stall_front,
             bubble_ex, flush_front, kill_ex_b, div_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  dcache_busy, div_req, div_done, ld_use, EX_br_a, EX_br_b, WB_flush_csr,
      output div_start, div_cancel, stall_dcache, stall_div, stall_front,
             bubble_ex, flush_front, kill_ex_b, div_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the dual-issue in-order pipeline.
// Merges dcache-miss, divider, load-use, branch-mispredict and CSR/exception
// flush events into per-stage controls and sequences the shared divider.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   hz       : pipe_hazard_ctrl_if.slave (events in, controls out)
// Stall/flush controls are combinational on the current events (forced low
// during reset); div_timeout and the performance counters are registered.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYC   = 1,
   parameter int unsigned DIV_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int unsigned FC_W = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
   localparam int unsigned TO_W = $clog2(DIV_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_DIV_WAIT = 2'd1,
      S_FLUSH    = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [FC_W-1:0]  fl_left_q, fl_left_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             armed_q, armed_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic csr_flush;
   logic stall_dc;
   logic stall_dv;
   logic div_start_c;
   logic div_cancel_c;
   logic flush_hold;
   logic high_pri;
   logic lu_ok;
   logic br_ok;
   logic front_flush;

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         fl_left_q   <= '0;
         to_cnt_q    <= '0;
         armed_q     <= 1'b1;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         fl_left_q   <= fl_left_d;
         to_cnt_q    <= to_cnt_d;
         armed_q     <= armed_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next state, divider sequencing and hazard controls
   always_comb begin
      state_d      = state_q;
      fl_left_d    = fl_left_q;
      to_cnt_d     = to_cnt_q;
      armed_d      = armed_q;
      timeout_d    = timeout_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      div_start_c  = 1'b0;
      div_cancel_c = 1'b0;
      stall_dv     = 1'b0;
      flush_hold   = 1'b0;

      csr_flush = hz.WB_flush_csr;
      stall_dc  = hz.dcache_busy & ~csr_flush;

      if (csr_flush) begin
         // Flush overrides everything; an in-flight divide is aborted and the
         // flushed instruction cannot block the next divide.
         div_cancel_c = (state_q == S_DIV_WAIT);
         state_d      = (FLUSH_CYC == 0) ? S_RUN : S_FLUSH;
         fl_left_d    = FC_W'(FLUSH_CYC);
         armed_d      = 1'b1;
      end else begin
         unique case (state_q)
            S_RUN: begin
               // A divide only re-arms once div_req has been seen low in RUN.
               if (!hz.div_req) armed_d = 1'b1;
               if (hz.div_req && armed_q && !hz.dcache_busy) begin
                  div_start_c = 1'b1;
                  stall_dv    = 1'b1;
                  state_d     = S_DIV_WAIT;
                  to_cnt_d    = '0;
               end
            end
            S_DIV_WAIT: begin
               if (hz.div_done) begin
                  state_d = S_RUN;
                  armed_d = 1'b0;
               end else begin
                  stall_dv = 1'b1;
                  if (to_cnt_q != TO_W'(DIV_TIMEOUT)) to_cnt_d = TO_W'(to_cnt_q + 1'b1);
                  if (to_cnt_q >= TO_W'(DIV_TIMEOUT - 1)) timeout_d = 1'b1;
               end
            end
            S_FLUSH: begin
               flush_hold = 1'b1;
               fl_left_d  = FC_W'(fl_left_q - 1'b1);
               if (fl_left_q <= FC_W'(1)) state_d = S_RUN;
            end
            default: state_d = S_RUN;
         endcase
      end

      // Load-use and branches yield to flush and to any pipeline freeze;
      // a branch beats load-use, leaving only the bubble from the load-use.
      high_pri    = csr_flush | stall_dc | stall_dv;
      lu_ok       = hz.ld_use & ~high_pri;
      br_ok       = (hz.EX_br_a | hz.EX_br_b) & ~high_pri;
      front_flush = csr_flush | flush_hold | br_ok;

      if ((stall_dc | stall_dv) && (stall_cnt_q != '1)) stall_cnt_d = CNT_W'(stall_cnt_q + 1'b1);
      if (csr_flush && (flush_cnt_q != '1))             flush_cnt_d = CNT_W'(flush_cnt_q + 1'b1);
   end

   assign hz.div_start    = div_start_c  & ~rst;
   assign hz.div_cancel   = div_cancel_c & ~rst;
   assign hz.stall_dcache = stall_dc     & ~rst;
   assign hz.stall_div    = stall_dv     & ~rst;
   assign hz.stall_front  = lu_ok & ~front_flush & ~rst;
   assign hz.bubble_ex    = lu_ok        & ~rst;
   assign hz.flush_front  = front_flush  & ~rst;
   assign hz.kill_ex_b    = hz.EX_br_a & br_ok & ~rst;
   assign hz.div_timeout  = timeout_q;
   assign hz.stall_cnt    = stall_cnt_q;
   assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized events checked every cycle against a
// behavioural model of the scheduling rules.
module tb_pipe_hazard_ctrl;

   localparam int unsigned FLUSH_CYC   = 1;
   localparam int unsigned DIV_TIMEOUT = 64;
   localparam int unsigned CNT_W       = 6;
   localparam int unsigned CNT_MAX     = (2 ** CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(
      .FLUSH_CYC  (FLUSH_CYC),
      .DIV_TIMEOUT(DIV_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of events just after the rising edge.
   task automatic step(input bit r, input bit busy, input bit dreq, input bit ddone,
                       input bit lu, input bit bra, input bit brb, input bit csr);
      @(posedge clk);
      #1;
      rst             = r;
      hz.dcache_busy  = busy;
      hz.div_req      = dreq;
      hz.div_done     = ddone;
      hz.ld_use       = lu;
      hz.EX_br_a      = bra;
      hz.EX_br_b      = brb;
      hz.WB_flush_csr = csr;
      #1;
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   bit          m_valid = 1'b0;
   bit          m_in_div, m_armed, m_timeout;
   int unsigned m_left, m_wait, m_stall_cnt, m_flush_cnt;

   always @(negedge clk) begin
      bit e_sd, e_sdv, e_start, e_cancel, e_ff, e_kill, e_sf, e_bub;
      bit freeze, lu_ok, br_ok, in_fl;
      in_fl    = (m_left > 0);
      e_sd     = hz.dcache_busy && !hz.WB_flush_csr;
      e_start  = !hz.WB_flush_csr && !m_in_div && !in_fl && hz.div_req && m_armed && !hz.dcache_busy;
      e_sdv    = !hz.WB_flush_csr && (e_start || (m_in_div && !hz.div_done));
      e_cancel = hz.WB_flush_csr && m_in_div;
      freeze   = hz.WB_flush_csr || e_sd || e_sdv;
      lu_ok    = hz.ld_use && !freeze;
      br_ok    = (hz.EX_br_a || hz.EX_br_b) && !freeze;
      e_ff     = hz.WB_flush_csr || in_fl || br_ok;
      e_kill   = hz.EX_br_a && br_ok;
      e_sf     = lu_ok && !e_ff;
      e_bub    = lu_ok;
      if (rst) {e_sd, e_sdv, e_start, e_cancel, e_ff, e_kill, e_sf, e_bub} = '0;

      if (m_valid) begin
         chk("div_start",    hz.div_start,    e_start);
         chk("div_cancel",   hz.div_cancel,   e_cancel);
         chk("stall_dcache", hz.stall_dcache, e_sd);
         chk("stall_div",    hz.stall_div,    e_sdv);
         chk("stall_front",  hz.stall_front,  e_sf);
         chk("bubble_ex",    hz.bubble_ex,    e_bub);
         chk("flush_front",  hz.flush_front,  e_ff);
         chk("kill_ex_b",    hz.kill_ex_b,    e_kill);
         chk("div_timeout",  hz.div_timeout,  m_timeout);
         chk("stall_cnt",    hz.stall_cnt,    m_stall_cnt);
         chk("flush_cnt",    hz.flush_cnt,    m_flush_cnt);
      end

      // Advance the model to what the next rising edge commits.
      if (rst) begin
         m_valid = 1'b1; m_in_div = 1'b0; m_armed = 1'b1; m_timeout = 1'b0;
         m_left = 0; m_wait = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
         if ((e_sd || e_sdv) && m_stall_cnt < CNT_MAX) m_stall_cnt++;
         if (hz.WB_flush_csr) begin
            if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
            m_in_div = 1'b0;
            m_left   = FLUSH_CYC;
            m_armed  = 1'b1;
         end else if (in_fl) begin
            m_left--;
         end else if (e_start) begin
            m_in_div = 1'b1;
            m_wait   = 0;
         end else if (m_in_div) begin
            if (hz.div_done) begin
               m_in_div = 1'b0;
               m_armed  = 1'b0;
            end else begin
               m_wait++;
               if (m_wait >= DIV_TIMEOUT) m_timeout = 1'b1;
            end
         end else if (!hz.div_req) begin
            m_armed = 1'b1;
         end
      end
   end

   // ---------------- directed scenarios + random phase ----------------
   initial begin
      bit dreq;
      rst = 1'b1;
      {hz.dcache_busy, hz.div_req, hz.div_done, hz.ld_use} = '0;
      {hz.EX_br_a, hz.EX_br_b, hz.WB_flush_csr} = '0;

      // Reset then idle
      step(1,0,0,0,0,0,0,0);
      step(1,0,0,0,0,0,0,0);
      step(0,0,0,0,0,0,0,0);
      chk("rst_outputs", {hz.div_start, hz.div_cancel, hz.stall_dcache, hz.stall_div,
                          hz.stall_front, hz.bubble_ex, hz.flush_front, hz.kill_ex_b,
                          hz.div_timeout}, 0);
      chk("rst_stall_cnt", hz.stall_cnt, 0);
      chk("rst_flush_cnt", hz.flush_cnt, 0);

      // Divide: start, 6 wait cycles, done; held div_req must not retrigger
      step(0,0,1,0,0,0,0,0);
      chk("div_start_first", hz.div_start, 1);
      chk("div_stall_first", hz.stall_div, 1);
      for (int i = 0; i < 6; i++) begin
         step(0,0,1,0,0,0,0,0);
         chk("div_start_once", hz.div_start, 0);
         chk("div_stall_wait", hz.stall_div, 1);
      end
      step(0,0,1,1,0,0,0,0);
      chk("div_done_stall", hz.stall_div, 0);
      step(0,0,1,0,0,0,0,0);
      chk("div_no_retrigger", hz.div_start, 0);
      chk("div_stall_cnt", hz.stall_cnt, 7);
      step(0,0,0,0,0,0,0,0);

      // Flush during divide
      step(0,0,1,0,0,0,0,0);
      step(0,0,1,0,0,0,0,0);
      step(0,0,1,0,0,0,0,0);
      step(0,0,1,0,0,0,0,1);
      chk("fl_cancel", hz.div_cancel, 1);
      chk("fl_front_req", hz.flush_front, 1);
      chk("fl_stall_div", hz.stall_div, 0);
      step(0,0,0,0,0,0,0,0);
      chk("fl_front_hold", hz.flush_front, 1);
      chk("fl_cancel_once", hz.div_cancel, 0);
      step(0,0,0,0,0,0,0,0);
      chk("fl_front_end", hz.flush_front, 0);
      chk("fl_flush_cnt", hz.flush_cnt, 1);
      chk("fl_stall_cnt", hz.stall_cnt, 10);

      // Branch held off by dcache stall
      step(0,1,0,0,0,0,0,0);
      chk("dc_stall", hz.stall_dcache, 1);
      step(0,1,0,0,0,1,0,0);
      chk("dc_br_held_ff", hz.flush_front, 0);
      chk("dc_br_held_kill", hz.kill_ex_b, 0);
      step(0,1,0,0,0,1,0,0);
      chk("dc_stall_last", hz.stall_dcache, 1);
      step(0,0,0,0,0,1,0,0);
      chk("dc_br_ff", hz.flush_front, 1);
      chk("dc_br_kill", hz.kill_ex_b, 1);
      chk("dc_released", hz.stall_dcache, 0);

      // Load-use alone, then load-use with B-slot branch
      step(0,0,0,0,1,0,0,0);
      chk("lu_stall_front", hz.stall_front, 1);
      chk("lu_bubble", hz.bubble_ex, 1);
      step(0,0,0,0,1,0,1,0);
      chk("lubr_ff", hz.flush_front, 1);
      chk("lubr_bubble", hz.bubble_ex, 1);
      chk("lubr_stall_front", hz.stall_front, 0);
      chk("lubr_kill", hz.kill_ex_b, 0);
      step(0,0,0,0,0,0,0,0);

      // Divider timeout: sticky until reset
      step(0,0,1,0,0,0,0,0);
      for (int k = 1; k <= DIV_TIMEOUT; k++) step(0,0,1,0,0,0,0,0);
      chk("to_before", hz.div_timeout, 0);
      step(0,0,1,0,0,0,0,0);
      chk("to_raised", hz.div_timeout, 1);
      for (int k = 0; k < 5; k++) step(0,0,1,0,0,0,0,0);
      chk("to_sticky", hz.div_timeout, 1);
      chk("to_still_wait", hz.stall_div, 1);
      step(1,0,1,0,0,0,0,0);
      chk("rst_mid_div_cancel", hz.div_cancel, 0);
      step(1,0,0,0,0,0,0,0);
      step(0,0,0,0,0,0,0,0);
      chk("to_cleared", hz.div_timeout, 0);

      // Random events, checked every cycle by the model
      dreq = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) dreq = ~dreq;
         step($urandom_range(299) == 0,
              $urandom_range(4) == 0,
              dreq,
              $urandom_range(7) == 0,
              $urandom_range(3) == 0,
              $urandom_range(5) == 0,
              $urandom_range(5) == 0,
              $urandom_range(15) == 0);
      end
      step(0,0,0,0,0,0,0,0);
      step(0,0,0,0,0,0,0,0);
      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
